// File: rtl/mux4way16_rr_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux4way16_rr_arbiter_pkg                                        |
// | Purpose  : Shared word width, Mux4Way16 select encodings and the rotating   |
// |            priority search used by the four-way round-robin arbiter.       |
// | Contents : WORD_W, SEL_IN1..SEL_IN4, CNT_W, sel_t, rr_pick()                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package mux4way16_rr_arbiter_pkg;

   localparam int WORD_W = 16;
   localparam int CNT_W  = 4;

   typedef logic [1:0] sel_t;

   // Select encodings shared with Mux4Way16: in1 is 2'b00 ... in4 is 2'b11.
   localparam sel_t SEL_IN1 = 2'b00;
   localparam sel_t SEL_IN2 = 2'b01;
   localparam sel_t SEL_IN3 = 2'b10;
   localparam sel_t SEL_IN4 = 2'b11;

   // First set bit of req searched from last+1, wrapping modulo 4.
   // Offsets are walked from farthest to nearest so the nearest hit wins;
   // offset 4 (== last itself) is therefore the lowest priority.
   function automatic sel_t rr_pick(input logic [3:0] req, input sel_t last);
      sel_t pick;
      sel_t idx;
      pick = sel_t'(last + 2'd1);
      for (int k = 4; k >= 1; k--) begin
         idx = sel_t'(last + sel_t'(k));
         if (req[idx]) pick = idx;
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mux4way16_rr_arbiter_mux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : Mux4Way16                                                       |
// | Purpose  : Four-input, 16-bit word multiplexer.                            |
// | Ports    : in1..in4 [WORD_W] in - candidate words                          |
// |            sel      [2]      in - 00 selects in1 ... 11 selects in4        |
// |            out      [WORD_W] out - selected word                           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module Mux4Way16
   import mux4way16_rr_arbiter_pkg::*;
(
   input  logic [WORD_W-1:0] in1,
   input  logic [WORD_W-1:0] in2,
   input  logic [WORD_W-1:0] in3,
   input  logic [WORD_W-1:0] in4,
   input  sel_t              sel,
   output logic [WORD_W-1:0] out
);

   always_comb begin
      out = in1;
      case (sel)
         SEL_IN1: out = in1;
         SEL_IN2: out = in2;
         SEL_IN3: out = in3;
         SEL_IN4: out = in4;
         default: out = in1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mux4way16_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mux4way16_rr_arbiter                                            |
// | Purpose  : Shares one 16-bit word path among four valid/ready requesters   |
// |            with round-robin arbitration and a BURST-word ownership lock.   |
// |            The granted word goes through Mux4Way16 into a one-entry        |
// |            output register.                                                |
// | Params   : BURST (1..15) - max consecutive words per requester             |
// | Ports    : clk                in  - clock, rising edge                     |
// |            rst_n              in  - async assert, active-low reset         |
// |            req_valid [4]      in  - requester i offers a word              |
// |            req_ready [4]      out - one-hot accept of requester i          |
// |            in1..in4  [16]     in  - words of requesters 0..3               |
// |            out       [16]     out - registered word                        |
// |            out_valid          out - out holds an unconsumed word           |
// |            out_ready          in  - consumer takes out this cycle          |
// |            src       [2]      out - requester that produced out            |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module mux4way16_rr_arbiter
   import mux4way16_rr_arbiter_pkg::*;
#(
   parameter int BURST = 1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req_valid,
   output logic [3:0]        req_ready,
   input  logic [WORD_W-1:0] in1,
   input  logic [WORD_W-1:0] in2,
   input  logic [WORD_W-1:0] in3,
   input  logic [WORD_W-1:0] in4,
   output logic [WORD_W-1:0] out,
   output logic              out_valid,
   input  logic              out_ready,
   output sel_t              src
);

   localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST);

   sel_t             last;
   sel_t             owner;
   logic [CNT_W-1:0] burst_cnt;

   logic             load_en;
   logic             any_valid;
   logic             lock_hold;
   logic             accept;
   sel_t             g;
   logic [WORD_W-1:0] mux_out;
   logic [CNT_W-1:0] cnt_next;

   assign load_en   = !out_valid || out_ready;
   assign any_valid = |req_valid;

   // The owner keeps the path while it still has words and quota left;
   // a dropped req_valid releases it to rotation in the same cycle.
   assign lock_hold = req_valid[owner] && (burst_cnt < BURST_LIM);
   assign g         = lock_hold ? owner : rr_pick(req_valid, last);

   // Gated by rst_n so no requester sees an accept while reset is held.
   assign accept    = rst_n && load_en && any_valid;

   // Saturate at BURST: when the owner is re-granted by rotation (nobody
   // else valid) the count must not wrap and re-arm a stale lock.
   always_comb begin
      cnt_next = CNT_W'(1);
      if (g == owner) begin
         cnt_next = (burst_cnt >= BURST_LIM) ? BURST_LIM : burst_cnt + CNT_W'(1);
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_ready
      assign req_ready[i] = accept && (g == sel_t'(i));
   end

   Mux4Way16 u_mux (
      .in1 (in1),
      .in2 (in2),
      .in3 (in3),
      .in4 (in4),
      .sel (g),
      .out (mux_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= '0;
         out_valid <= 1'b0;
         src       <= SEL_IN1;
         last      <= SEL_IN4;
         owner     <= SEL_IN1;
         burst_cnt <= '0;
      end else if (accept) begin
         out       <= mux_out;
         src       <= g;
         out_valid <= 1'b1;
         last      <= g;
         owner     <= g;
         burst_cnt <= cnt_next;
      end else if (load_en) begin
         // Register drained (or empty) and nobody asking: go idle, drop lock.
         out_valid <= 1'b0;
         burst_cnt <= '0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mux4way16_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_mux4way16_rr_arbiter                                         |
// | Purpose  : Scoreboard bench for mux4way16_rr_arbiter. Two instances share  |
// |            stimulus: BURST=1 (pure round-robin) and BURST=3 (lock). Each   |
// |            phase queues hand-computed {word,src} pairs; a negedge monitor  |
// |            pops one per consumed output word.                              |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_mux4way16_rr_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] in1, in2, in3, in4;
   logic        out_ready;

   logic [3:0]  rr1, rr3;
   logic [15:0] o1, o3;
   logic        v1, v3;
   logic [1:0]  s1, s3;

   int total = 0;
   int bad   = 0;

   logic [17:0] q1[$];
   logic [17:0] q3[$];
   logic [17:0] e1, e3;
   bit          mon1_en, mon3_en;

   always #5 clk = ~clk;

   mux4way16_rr_arbiter #(.BURST(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr1),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .out(o1), .out_valid(v1), .out_ready(out_ready), .src(s1)
   );

   mux4way16_rr_arbiter #(.BURST(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rr3),
      .in1(in1), .in2(in2), .in3(in3), .in4(in4),
      .out(o3), .out_valid(v3), .out_ready(out_ready), .src(s3)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset both instances, then release just after an edge so the next
   // rising edge is the first accept edge.
   task automatic start(input logic [3:0] rv);
      rst_n     = 1'b0;
      req_valid = rv;
      out_ready = 1'b1;
      step();
      rst_n = 1'b1;
   endtask

   function automatic void push1(input logic [15:0] w, input logic [1:0] s);
      q1.push_back({w, s});
   endfunction

   function automatic void push3(input logic [15:0] w, input logic [1:0] s);
      q3.push_back({w, s});
   endfunction

   // Monitor: a word is consumed when out_valid && out_ready at the edge;
   // sampled on the falling edge while inputs are stable.
   always @(negedge clk) begin
      if (mon1_en && v1 && out_ready) begin
         if (q1.size() == 0) begin
            total++; bad++;
            $display("FAIL sb1_extra: got %h/%0d expected no word", o1, s1);
         end else begin
            e1 = q1.pop_front();
            chk("sb1_word", 32'(o1), 32'(e1[17:2]));
            chk("sb1_src",  32'(s1), 32'(e1[1:0]));
         end
      end
      if (mon3_en && v3 && out_ready) begin
         if (q3.size() == 0) begin
            total++; bad++;
            $display("FAIL sb3_extra: got %h/%0d expected no word", o3, s3);
         end else begin
            e3 = q3.pop_front();
            chk("sb3_word", 32'(o3), 32'(e3[17:2]));
            chk("sb3_src",  32'(s3), 32'(e3[1:0]));
         end
      end
   end

   initial begin
      in1 = 16'hdadf; in2 = 16'haaaf; in3 = 16'hbdef; in4 = 16'h1245;
      mon1_en = 1'b1; mon3_en = 1'b0;

      // ---- reset held with all inputs active ----
      rst_n = 1'b0; req_valid = 4'b1111; out_ready = 1'b1;
      step(); step();
      chk("rst_out",   32'(o1),  32'h0);
      chk("rst_valid", 32'(v1),  32'h0);
      chk("rst_src",   32'(s1),  32'h0);
      chk("rst_ready", 32'(rr1), 32'h0);
      chk("rst_ready3", 32'(rr3), 32'h0);

      // ---- round robin, BURST=1 ----
      push1(16'hdadf, 2'd0); push1(16'haaaf, 2'd1); push1(16'hbdef, 2'd2);
      push1(16'h1245, 2'd3); push1(16'hdadf, 2'd0);
      rst_n = 1'b1;
      #1 chk("rr_first_ready", 32'(rr1), 32'h1);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("rr_valid", 32'(v1), 32'h1);
      end
      req_valid = 4'b0000;
      step();
      chk("rr_idle_valid", 32'(v1), 32'h0);
      chk("rr_q_empty", 32'(q1.size()), 32'h0);

      // ---- burst lock, BURST=3 ----
      mon1_en = 1'b0; mon3_en = 1'b1;
      push3(16'hdadf, 2'd0); push3(16'hdadf, 2'd0); push3(16'hdadf, 2'd0);
      push3(16'haaaf, 2'd1); push3(16'haaaf, 2'd1); push3(16'haaaf, 2'd1);
      push3(16'hbdef, 2'd2);
      start(4'b1111);
      repeat (7) step();
      req_valid = 4'b0000;
      step();
      chk("burst_idle_valid", 32'(v3), 32'h0);
      chk("burst_q_empty", 32'(q3.size()), 32'h0);

      // ---- lock drop after two words ----
      push3(16'hdadf, 2'd0); push3(16'hdadf, 2'd0); push3(16'haaaf, 2'd1);
      start(4'b1111);
      step(); step();
      req_valid = 4'b1110;
      #1 chk("drop_ready", 32'(rr3), 32'h2);
      step();
      chk("drop_src", 32'(s3), 32'h1);
      req_valid = 4'b0000;
      step();
      chk("drop_q_empty", 32'(q3.size()), 32'h0);

      // ---- backpressure ----
      push3(16'hdadf, 2'd0); push3(16'hdadf, 2'd0);
      start(4'b1111);
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_out",   32'(o3),  32'hdadf);
         chk("bp_src",   32'(s3),  32'h0);
         chk("bp_valid", 32'(v3),  32'h1);
         chk("bp_ready", 32'(rr3), 32'h0);
      end
      out_ready = 1'b1;
      #1 chk("bp_resume_ready", 32'(rr3), 32'h1);
      step();
      chk("bp_reload_valid", 32'(v3), 32'h1);
      req_valid = 4'b0000;
      step();
      chk("bp_idle_valid", 32'(v3), 32'h0);
      chk("bp_q_empty", 32'(q3.size()), 32'h0);

      // ---- sparse requests, BURST=1 ----
      mon3_en = 1'b0; mon1_en = 1'b1;
      push1(16'haaaf, 2'd1); push1(16'h1245, 2'd3);
      push1(16'haaaf, 2'd1); push1(16'h1245, 2'd3);
      start(4'b1010);
      repeat (4) step();
      req_valid = 4'b0000;
      chk("sparse_last_valid", 32'(v1), 32'h1);
      step();
      chk("sparse_idle_valid", 32'(v1), 32'h0);
      chk("sparse_q_empty", 32'(q1.size()), 32'h0);

      // ---- async reset mid-burst (requester 1 owns the path) ----
      mon1_en = 1'b0; mon3_en = 1'b1;
      push3(16'hdadf, 2'd0); push3(16'hdadf, 2'd0); push3(16'hdadf, 2'd0);
      start(4'b1111);
      repeat (4) step();
      chk("pre_rst_src", 32'(s3), 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out",   32'(o3),  32'h0);
      chk("arst_valid", 32'(v3),  32'h0);
      chk("arst_src",   32'(s3),  32'h0);
      chk("arst_ready", 32'(rr3), 32'h0);
      push3(16'hdadf, 2'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1 chk("restart_ready", 32'(rr3), 32'h1);
      step();
      chk("restart_src", 32'(s3), 32'h0);
      req_valid = 4'b0000;
      step();
      chk("restart_q_empty", 32'(q3.size()), 32'h0);
      chk("final_q1_empty", 32'(q1.size()), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
